multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Moore/Mealy FSM that sequences the RV64 datapath (fetch, decode, execute, data memory, write-back) over multiple cycles instead of one.
- Handles ready/request handshakes with the instruction and data memories and enforces a bus timeout.
- Provides halt and trap control and keeps cycle and retired-instruction counters.
- Sits beside the datapath; drives all its enables and muxes from the opcode and funct3 fields of the instruction register.

Parameters:
- CNT_W, 64, width of cycle_cnt and instret_cnt.
- TIMEOUT, 15, max cycles waiting for a ready in FETCH or MEM before a bus error; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- opcode  input  7  inst[6:0] from the instruction register.
- funct3  input  3  inst[14:12].
- alu_zero  input  1  ALU result == 0.
- if_ready  input  1  instruction memory has data this cycle.
- dmem_ready  input  1  data memory access completes this cycle.
- halt_req  input  1  request to stop at the next instruction boundary.
- if_req  output  1  instruction fetch request.
- ir_we  output  1  load the instruction register.
- pc_we  output  1  update the PC.
- pc_sel  output  1  0 = PC+4, 1 = branch target.
- reg_we  output  1  register file write.
- mem_read  output  1  data memory read.
- mem_write  output  1  data memory write.
- alu_src  output  1  0 = rs2, 1 = immediate.
- mem_to_reg  output  1  write-back source: 1 = memory.
- alu_op  output  2  00 add, 01 sub/compare, 10 funct-decoded.
- state  output  3  current state.
- illegal  output  1  sticky, unsupported instruction.
- bus_err  output  1  sticky, handshake timeout.
- halted  output  1  in HALT.
- cycle_cnt  output  CNT_W  active cycle count.
- instret_cnt  output  CNT_W  retired instruction count.

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state=FETCH; the class register, wait counter, both perf counters, illegal and bus_err clear to 0.
  - All combinational outputs are 0 while reset is held, including if_req.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- Instruction class, captured in DECODE from opcode:
  - 0110011 is R.
  - 0010011 is I.
  - 0000011 is LD.
  - 0100011 is ST.
  - 1100011 is BR; only funct3 000 (beq) and 001 (bne) are legal.
  - Anything else is illegal.
- FETCH:
  - If halt_req=1: if_req=0, next state HALT.
  - Otherwise if_req=1.
  - If if_ready=1: ir_we=1 in the same cycle, next state DECODE.
- DECODE: on a legal class, capture it and go to EXEC; on an illegal class, set illegal and go to TRAP. No outputs asserted.
- EXEC:
  - R: alu_src=0, alu_op=10, next WB.
  - I: alu_src=1, alu_op=10, next WB.
  - LD/ST: alu_src=1, alu_op=00, next MEM.
  - BR: alu_src=0, alu_op=01, pc_we=1, pc_sel=(beq ? alu_zero : !alu_zero); the branch retires; next FETCH.
- MEM:
  - alu_src=1 and alu_op=00 are held.
  - LD asserts mem_read; ST asserts mem_write.
  - Until dmem_ready=1, stay in MEM.
  - On ready, LD goes to WB; ST asserts pc_we=1, pc_sel=0, retires, and goes to FETCH.
- WB: reg_we=1, mem_to_reg=(class==LD), alu_src per class, pc_we=1, pc_sel=0; retires; next FETCH.
- HALT: halted=1, all enables 0; return to FETCH when halt_req=0. halt_req is ignored outside FETCH, so an instruction in flight always completes.
- TRAP: all enables 0; stays until reset.
- Timeout:
  - The wait counter counts consecutive cycles in FETCH (with if_req=1) or MEM without ready.
  - It clears on a state change or on ready.
  - When it reaches TIMEOUT (TIMEOUT>0): set bus_err, go to TRAP; no enables are asserted that cycle.
  - A ready arriving in the same cycle as the timeout wins.
- cycle_cnt increments every cycle the state is not HALT or TRAP.
- instret_cnt increments on each retire cycle.
- Both counters wrap modulo 2^CNT_W.

Decomposition:
- Shared package holds:
  - the opcode constants;
  - the state encoding;
  - the class encoding (R, I, LD, ST, BR);
  - the alu_op encodings (00, 01, 10).
- One sub-module, ctrl_perf_counters: cycle and instret counters with enable and wrap, parameterised by CNT_W.

Test Plan:
- R-type add, if_ready tied to 1 -> states 0,1,2,4,0 over 4 cycles; reg_we=1 only in the 4th cycle; instret_cnt=1 and cycle_cnt=4 afterwards.
- Load with dmem_ready raised 3 cycles after MEM entry -> mem_read high for 4 cycles; total latency 8 cycles; mem_to_reg=1 in WB.
- bne with alu_zero=1 -> pc_we=1 and pc_sel=0 in EXEC; beq with alu_zero=1 -> pc_sel=1; both take 3 cycles.
- opcode 1111111 -> TRAP after DECODE, illegal=1; cycle_cnt frozen at 2; state stays 6 until rst=0.
- if_ready held 0 with TIMEOUT=15 -> bus_err=1 and state=6 after 15 FETCH cycles; rerun with TIMEOUT=0 -> never traps.
- halt_req raised during EXEC of an add -> the add completes, then HALT with halted=1 and cycle_cnt frozen; drop halt_req -> FETCH resumes.
- rst=0 asserted mid-MEM -> state=0 and counters=0 immediately, asynchronously.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared opcodes, state/class encodings and ALU op codes
// for the multicycle RV64 controller.
package multicycle_controller_pkg;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_TRAP   = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      CL_NONE = 3'd0,
      CL_R    = 3'd1,
      CL_I    = 3'd2,
      CL_LD   = 3'd3,
      CL_ST   = 3'd4,
      CL_BR   = 3'd5
   } class_e;

   // CL_NONE doubles as the "illegal instruction" result.
   function automatic class_e decode_class(input logic [6:0] op, input logic [2:0] f3);
      return op == OP_R  ? CL_R  :
             op == OP_I  ? CL_I  :
             op == OP_LD ? CL_LD :
             op == OP_ST ? CL_ST :
             (op == OP_BR && (f3 == F3_BEQ || f3 == F3_BNE)) ? CL_BR : CL_NONE;
   endfunction

endpackage

// File: rtl/multicycle_controller_perf_counters.sv
// ctrl_perf_counters: free-running cycle and retired-instruction counters with
// enables, wrapping modulo 2^CNT_W.
module ctrl_perf_counters #(
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cyc_en_i,
   input  logic             ret_en_i,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic [CNT_W-1:0] instret_cnt_o
);

   logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;

   assign cyc_d = cyc_en_i ? cyc_q + 1'b1 : cyc_q;
   assign ret_d = ret_en_i ? ret_q + 1'b1 : ret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc_q <= '0;
         ret_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ret_q <= ret_d;
      end
   end

   assign cycle_cnt_o   = cyc_q;
   assign instret_cnt_o = ret_q;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64 datapath
// with memory handshakes, bus timeout, halt/trap control and perf counters.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int CNT_W   = 64,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             alu_zero,
   input  logic             if_ready,
   input  logic             dmem_ready,
   input  logic             halt_req,
   output logic             if_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             reg_we,
   output logic             mem_read,
   output logic             mem_write,
   output logic             alu_src,
   output logic             mem_to_reg,
   output logic [1:0]       alu_op,
   output logic [2:0]       state,
   output logic             illegal,
   output logic             bus_err,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   localparam int WW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

   state_e        state_q, state_d;
   class_e        class_q, class_d, dec_class;
   logic [WW-1:0] wait_q, wait_d;
   logic          illegal_q, illegal_d, bus_err_q, bus_err_d;
   logic          waiting, timeout, retire, cyc_en, is_ld, is_st, is_br, is_alu;

   assign dec_class = decode_class(opcode, funct3);
   assign is_ld     = class_q == CL_LD;
   assign is_st     = class_q == CL_ST;
   assign is_br     = class_q == CL_BR;
   assign is_alu    = class_q == CL_R || class_q == CL_I;
   assign cyc_en    = state_q != S_HALT && state_q != S_TRAP;

   // A ready in the same cycle masks "waiting", so it always beats the timeout.
   assign waiting = (state_q == S_FETCH && !halt_req && !if_ready) ||
                    (state_q == S_MEM && !dmem_ready);
   assign timeout = (TIMEOUT > 0) && waiting && (wait_q == WW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_FETCH;
         class_q   <= CL_NONE;
         wait_q    <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q | timeout;
      wait_d    = ((TIMEOUT > 0) && waiting && !timeout) ? wait_q + 1'b1 : '0;
      case (state_q)
         S_FETCH:  state_d = halt_req ? S_HALT : if_ready ? S_DECODE : timeout ? S_TRAP : S_FETCH;
         S_DECODE: begin
            class_d   = dec_class == CL_NONE ? class_q : dec_class;
            illegal_d = illegal_q | (dec_class == CL_NONE);
            state_d   = dec_class == CL_NONE ? S_TRAP : S_EXEC;
         end
         S_EXEC:   state_d = is_alu ? S_WB : is_br ? S_FETCH : S_MEM;
         S_MEM:    state_d = dmem_ready ? (is_ld ? S_WB : S_FETCH) : timeout ? S_TRAP : S_MEM;
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = halt_req ? S_HALT : S_FETCH;
         default:  state_d = S_TRAP;
      endcase
   end

   always_comb begin
      if_req     = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 1'b0;
      reg_we     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = ALU_ADD;
      halted     = 1'b0;
      retire     = 1'b0;
      if (rst) begin
         case (state_q)
            S_FETCH: begin
               if_req = !halt_req && !timeout;
               ir_we  = !halt_req && if_ready;
            end
            S_EXEC: begin
               alu_src = !(class_q == CL_R || is_br);
               alu_op  = is_br ? ALU_SUB : is_alu ? ALU_FUNCT : ALU_ADD;
               pc_we   = is_br;
               pc_sel  = is_br && (funct3 == F3_BEQ ? alu_zero : !alu_zero);
               retire  = is_br;
            end
            S_MEM: begin
               alu_src   = !timeout;
               mem_read  = !timeout && is_ld;
               mem_write = !timeout && is_st;
               pc_we     = is_st && dmem_ready;
               retire    = is_st && dmem_ready;
            end
            S_WB: begin
               reg_we     = 1'b1;
               mem_to_reg = is_ld;
               alu_src    = class_q != CL_R;
               pc_we      = 1'b1;
               retire     = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign state   = state_q;
   assign illegal = illegal_q;
   assign bus_err = bus_err_q;

   ctrl_perf_counters #(.CNT_W(CNT_W)) u_perf (
      .clk          (clk),
      .rst_n        (rst),
      .cyc_en_i     (cyc_en),
      .ret_en_i     (retire),
      .cycle_cnt_o  (cycle_cnt),
      .instret_cnt_o(instret_cnt)
   );

endmodule
